// File: rtl/syncram_bist.sv
// syncram_bist: March-style BIST initiator for a synchronous single-port RAM.
// Sequence: W0 (write BG ascending), R0W1 (read BG / write ~BG ascending),
// R1W0 (read ~BG / write BG descending), R0 (read BG ascending), FLUSH, DONE.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   start                - run request, only honoured in IDLE
//   adress, WD, WE       - RAM address / write data / write enable (registered)
//   Q                    - RAM read data, valid one cycle after its address
//   busy, done, pass     - run in progress, end-of-run pulse, last result
//   fail_addr, fail_data - first mismatch address and read value
// Optional feature: define BIST_FAIL_LOG_EN to capture fail_addr/fail_data;
// otherwise both stay 0.
module syncram_bist #(
  parameter int unsigned       ADDR_W = 8,
  parameter int unsigned       DATA_W = 8,
  parameter logic [DATA_W-1:0] BG     = DATA_W'(8'h00)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] adress,
  output logic [DATA_W-1:0] WD,
  output logic              WE,
  input  logic [DATA_W-1:0] Q,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic [2:0] {IDLE, W0, R0W1, R1W0, R0, FLUSH, DONE} state_t;

  state_t            state, state_nxt;
  logic              half, half_nxt;     // 0: read cycle A, 1: write cycle B
  logic              err, err_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wd_nxt;
  logic              we_nxt, busy_nxt, done_nxt, pass_nxt;
  logic [ADDR_W-1:0] fail_addr_nxt;
  logic [DATA_W-1:0] fail_data_nxt;
  logic              run_start, cmp_en, mismatch;
  logic [DATA_W-1:0] cmp_exp;
`ifdef BIST_FAIL_LOG_EN
  logic [ADDR_W-1:0] cmp_addr;
`endif

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      half      <= 1'b0;
      err       <= 1'b0;
      adress    <= '0;
      WD        <= '0;
      WE        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      state     <= state_nxt;
      half      <= half_nxt;
      err       <= err_nxt;
      adress    <= addr_nxt;
      WD        <= wd_nxt;
      WE        <= we_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      fail_addr <= fail_addr_nxt;
      fail_data <= fail_data_nxt;
    end
  end

  // Next state, address walk and A/B sub-cycle
  always_comb begin
    state_nxt = state;
    addr_nxt  = adress;
    half_nxt  = 1'b0;
    case (state)
      IDLE: begin
        addr_nxt = '0;
        if (start) state_nxt = W0;
      end
      W0: begin
        if (adress == LAST) begin
          state_nxt = R0W1;
          addr_nxt  = '0;
        end else begin
          addr_nxt = adress + ADDR_W'(1);
        end
      end
      R0W1: begin
        if (!half) begin
          half_nxt = 1'b1;
        end else if (adress == LAST) begin
          state_nxt = R1W0;
          addr_nxt  = LAST;
        end else begin
          addr_nxt = adress + ADDR_W'(1);
        end
      end
      R1W0: begin
        if (!half) begin
          half_nxt = 1'b1;
        end else if (adress == '0) begin
          state_nxt = R0;
          addr_nxt  = '0;
        end else begin
          addr_nxt = adress - ADDR_W'(1);
        end
      end
      R0: begin
        if (adress == LAST) begin
          state_nxt = FLUSH;
          addr_nxt  = '0;
        end else begin
          addr_nxt = adress + ADDR_W'(1);
        end
      end
      FLUSH: begin
        state_nxt = DONE;
        addr_nxt  = '0;
      end
      DONE: begin
        state_nxt = IDLE;
        addr_nxt  = '0;
      end
      default: begin
        state_nxt = IDLE;
        addr_nxt  = '0;
      end
    endcase
  end

  // Read-data compare and next values of the registered outputs
  always_comb begin
    run_start = (state == IDLE) && start;
    cmp_en    = 1'b0;
    cmp_exp   = BG;
    // Q in the current cycle belongs to the address driven one cycle earlier
    case (state)
      R0W1:    cmp_en = half;
      R1W0: begin
        cmp_en  = half;
        cmp_exp = ~BG;
      end
      R0:      cmp_en = (adress != '0);
      FLUSH:   cmp_en = 1'b1;
      default: cmp_en = 1'b0;
    endcase
    mismatch = cmp_en && (Q != cmp_exp);

    we_nxt = (state_nxt == W0) ||
             (((state_nxt == R0W1) || (state_nxt == R1W0)) && half_nxt);
    case (state_nxt)
      W0:      wd_nxt = BG;
      R0W1:    wd_nxt = ~BG;
      R1W0:    wd_nxt = BG;
      default: wd_nxt = '0;
    endcase
    busy_nxt = !((state_nxt == IDLE) || (state_nxt == DONE));
    done_nxt = (state_nxt == DONE);
    err_nxt  = run_start ? 1'b0 : (err | mismatch);
    pass_nxt = done_nxt ? !(err | mismatch) : pass;

`ifdef BIST_FAIL_LOG_EN
    cmp_addr = adress;
    if (state == R0)         cmp_addr = adress - ADDR_W'(1);
    else if (state == FLUSH) cmp_addr = LAST;
    fail_addr_nxt = fail_addr;
    fail_data_nxt = fail_data;
    if (run_start) begin
      fail_addr_nxt = '0;
      fail_data_nxt = '0;
    end else if (mismatch && !err) begin
      fail_addr_nxt = cmp_addr;
      fail_data_nxt = Q;
    end
`else
    fail_addr_nxt = '0;
    fail_data_nxt = '0;
`endif
  end

endmodule

// File: tb/tb_syncram_bist.sv
// Directed bench for syncram_bist with a behavioural read-first RAM and
// selectable read-data faults.
module tb_syncram_bist;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
`ifdef BIST_FAIL_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] adress;
  logic [DATA_W-1:0] WD;
  logic              WE;
  logic [DATA_W-1:0] Q;
  logic              busy, done, pass;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_data;

  logic [DATA_W-1:0] mem [256];
  logic [DATA_W-1:0] q_reg = '0;
  logic [ADDR_W-1:0] raddr = '0;
  int                cyc = 0;
  int                fault_mode = 0;
  int                n_cmp = 0;
  int                n_err = 0;

  syncram_bist dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .adress(adress), .WD(WD), .WE(WE), .Q(Q),
    .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  // Read-first synchronous RAM; cyc numbers cycles from the start-sampling edge
  always @(posedge clk) begin
    if (WE) mem[adress] <= WD;
    q_reg <= mem[adress];
    raddr <= adress;
    cyc   <= (rst_n && start && !busy && !done) ? 1 : cyc + 1;
  end

  // Fault 1: Q[3] stuck at 0. Fault 2: address 0x10 reads 0x01 during R0.
  always_comb begin
    Q = q_reg;
    if (fault_mode == 1)
      Q = q_reg & 8'hF7;
    else if (fault_mode == 2 && raddr == 8'h10 && cyc >= 1282)
      Q = 8'h01;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start present during cycle 0; returns at the negedge of cycle 1
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  int          wp_k  [8] = '{1, 256, 257, 258, 769, 770, 1281, 1282};
  logic [8:0]  wp_exp[8] = '{9'h100, 9'h1FF, 9'h000, 9'h100, 9'h0FF, 9'h1FF, 9'h000, 9'h001};
  int          wd_k  [3] = '{1, 258, 770};
  logic [7:0]  wd_exp[3] = '{8'h00, 8'hFF, 8'h00};

  task automatic run_bist(input string tag, input int fault, input logic exp_pass,
                          input logic [7:0] exp_fa, input logic [7:0] exp_fd, input bit wp);
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    fault_mode = fault;
    pulse_start();
    for (int k = 1; k <= 1545; k++) begin
      if (k > 1) @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = k;
        if (wp) check($sformatf("%s_done_bus", tag), 32'({busy, WE, adress, WD}), 32'(0));
      end
      if (wp) begin
        for (int i = 0; i < 8; i++)
          if (k == wp_k[i])
            check($sformatf("%s_we_addr_c%0d", tag, k), 32'({WE, adress}), 32'(wp_exp[i]));
        for (int i = 0; i < 3; i++)
          if (k == wd_k[i])
            check($sformatf("%s_wd_c%0d", tag, k), 32'(WD), 32'(wd_exp[i]));
      end
    end
    check($sformatf("%s_busy_cycles", tag), 32'(busy_cnt), 32'(1537));
    check($sformatf("%s_done_count", tag), 32'(done_cnt), 32'(1));
    check($sformatf("%s_done_cycle", tag), 32'(done_cyc), 32'(1538));
    check($sformatf("%s_pass", tag), 32'(pass), 32'(exp_pass));
    check($sformatf("%s_fail_addr", tag), 32'(fail_addr), 32'(exp_fa));
    check($sformatf("%s_fail_data", tag), 32'(fail_data), 32'(exp_fd));
    fault_mode = 0;
  endtask

  initial begin
    int dn;
    int d1;
    int d2;
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_pass", 32'(pass), 32'(0));
    check("rst_we", 32'(WE), 32'(0));
    check("rst_addr_wd", 32'({adress, WD}), 32'(0));
    check("rst_fail", 32'({fail_addr, fail_data}), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_bist("good", 0, 1'b1, 8'h00, 8'h00, 1'b1);
    run_bist("stuck3", 1, 1'b0, LOG ? 8'hFF : 8'h00, LOG ? 8'hF7 : 8'h00, 1'b0);
    run_bist("r0corrupt", 2, 1'b0, LOG ? 8'h10 : 8'h00, LOG ? 8'h01 : 8'h00, 1'b0);
    run_bist("rerun", 0, 1'b1, 8'h00, 8'h00, 1'b0);

    // Reset asserted for one cycle in cycle 700 of a run
    pulse_start();
    for (int k = 2; k <= 700; k++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_we", 32'(WE), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    @(negedge clk);
    check("abort_we_after", 32'(WE), 32'(0));
    dn = 0;
    for (int k = 0; k < 1600; k++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    check("abort_no_done", 32'(dn), 32'(0));
    run_bist("after_abort", 0, 1'b1, 8'h00, 8'h00, 1'b0);

    // start held high: one run per 1539 cycles
    dn = 0;
    d1 = 0;
    d2 = 0;
    @(negedge clk) start = 1'b1;
    for (int k = 1; k <= 3100; k++) begin
      @(negedge clk);
      if (done) begin
        dn++;
        if (dn == 1) d1 = k;
        else d2 = k;
      end
      if (k == 1539) check("hold_idle_gap", 32'(busy), 32'(0));
      if (k == 1540) check("hold_restart", 32'(busy), 32'(1));
      if (k == 3000) start = 1'b0;
    end
    check("hold_done_count", 32'(dn), 32'(2));
    check("hold_done1", 32'(d1), 32'(1538));
    check("hold_done2", 32'(d2), 32'(3077));
    check("hold_pass", 32'(pass), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/syncram_bist.md
SYNCRAM_BIST -- requirements
Module: syncram_bist

Interface
REQ-001 Parameter: ADDR_W, 8, address width; the RAM depth is 2**ADDR_W.
REQ-002 Parameter: DATA_W, 8, data width.
REQ-003 Parameter: BG, 8'h00, background pattern; the inverse pattern is ~BG.
REQ-004 The port list SHALL be as follows:
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  run request, sampled only in IDLE.
- adress  output  ADDR_W  RAM address; drives syncram adress.
- WD  output  DATA_W  RAM write data; drives syncram WD.
- WE  output  1  RAM write enable; drives syncram WE.
- Q  input  DATA_W  RAM read data, from syncram Q.
- busy  output  1  high while a test runs.
- done  output  1  one-cycle pulse at test end.
- pass  output  1  result of the last completed run.
- fail_addr  output  ADDR_W  address of the first mismatch.
- fail_data  output  DATA_W  Q value at the first mismatch.

Function
REQ-005 The block SHALL act as the initiator for syncram. The RAM registers adress/WE/WD on a rising edge, so Q for an address driven in cycle n is valid in cycle n+1.
REQ-006 The FSM SHALL have the states IDLE, W0, R0W1, R1W0, R0, FLUSH and DONE, and all outputs SHALL be registered.
REQ-007 In IDLE, start=1 SHALL move the FSM to W0 with address 0. While busy=1, start SHALL be ignored.
REQ-008 W0 SHALL write BG in ascending order from 0 to 2**ADDR_W-1, one address per cycle (WE=1), for 256 cycles.
REQ-009 R0W1 SHALL run in ascending order, 2 cycles per address:
- cycle A: WE=0 at address a;
- cycle B: WE=1, WD=~BG at address a, and Q is compared against BG at the end of cycle B.
REQ-010 R1W0 SHALL run in descending order from 2**ADDR_W-1 to 0, 2 cycles per address, expecting ~BG and writing BG, with the same A/B timing as R0W1.
REQ-011 R0 SHALL read in ascending order, 1 address per cycle (WE=0). Q in cycle n+1 is compared against BG for the address driven in cycle n. FLUSH SHALL add 1 cycle to compare the last address.
REQ-012 A phase transition SHALL occur on address wrap (255 ascending, 0 descending), with no idle cycle between phases.
REQ-013 Timing from the start-sampling edge: busy=1 for 1537 cycles (256+512+512+256+1). done=1 for exactly 1 cycle in DONE, then the FSM returns to IDLE.
REQ-014 A mismatch SHALL set a sticky error flag and SHALL NOT abort the run; the run always completes.
REQ-015 pass SHALL be updated at done to (no mismatch) and held until the next done. busy SHALL clear in the same cycle done asserts.
REQ-016 Outside W0/R0W1/R1W0, WE SHALL be 0. In IDLE and DONE, adress=0 and WD=0.
REQ-017 The error flag, fail_addr and fail_data SHALL clear on the cycle a new run starts.

Reset
REQ-018 rst_n=0 at a rising edge SHALL force:
- state=IDLE;
- adress=0, WD=0, WE=0;
- busy=0, done=0, pass=0;
- fail_addr=0, fail_data=0.
REQ-019 Reset during a run SHALL abort the run with no done pulse, and the first cycle after release SHALL have WE=0. RAM contents after an abort are undefined to the block.

Configuration
REQ-020 With BIST_FAIL_LOG_EN defined, fail_addr/fail_data SHALL capture the address and Q of the first mismatch only, and later mismatches SHALL NOT overwrite them.
REQ-021 Without BIST_FAIL_LOG_EN, fail_addr and fail_data SHALL be constant 0, and pass behaviour SHALL be unchanged.

Verification
REQ-022 Good RAM, start pulse at cycle 0: busy high cycles 1-1537, done in cycle 1538, pass=1, fail_addr=0.
REQ-023 Q[3] stuck at 0, BG=8'h00, LOG_EN defined: pass=0, fail_addr=8'hFF (first R1W0 read), fail_data=8'hF7.
REQ-024 Data corruption at address 8'h10 only during the R0 phase (Q=8'h01): pass=0, fail_addr=8'h10, fail_data=8'h01, and the run still lasts 1537 cycles.
REQ-025 rst_n=0 for 1 cycle at cycle 700: busy=0, WE=0, no done pulse. A new start then runs the full 1537 cycles with pass=1.
REQ-026 start held high for 3000 cycles: exactly one done per 1539 cycles (1537 busy + DONE + IDLE), and start is ignored while busy.
REQ-027 Without BIST_FAIL_LOG_EN, repeat the REQ-023 stimulus: pass=0, fail_addr=0, fail_data=0.
